// File: rtl/mem_sram_controller.sv
// Memory-stage data-memory controller: services 32-bit loads/stores as two
// half-word phases on a 16-bit asynchronous SRAM, freezing the pipeline meanwhile.
module mem_sram_controller #(
    parameter int unsigned ADDR_BASE    = 1024,
    parameter int unsigned PHASE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST = 4'(PHASE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;
    logic        w_req;
    logic        w_is_rd;
    logic        w_last;
    logic        w_phase;
    logic [16:0] w_word;

    assign w_req   = rd_en | wr_en;
    assign w_is_rd = rd_en & ~wr_en;
    assign w_last  = (r_cnt == LAST);
    assign w_phase = (r_state == S_LOW) | (r_state == S_HIGH);
    // Word index wraps modulo 2^17, including addresses below the base.
    assign w_word  = 17'((address - 32'(ADDR_BASE)) >> 2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_next     = S_LOW;
                    w_cnt_next = '0;
                end
            end
            S_LOW: begin
                if (w_last) begin
                    w_next     = S_HIGH;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_HIGH: begin
                if (w_last) begin
                    w_next     = S_DONE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            S_DONE: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    assign ready      = ((r_state == S_IDLE) & ~w_req) | (r_state == S_DONE);
    // Last cycle of each write phase keeps we_n high for data/address hold.
    assign sram_we_n  = ~(w_phase & wr_en & ~w_last);
    assign sram_oe_n  = ~(w_phase & w_is_rd);
    assign sram_dq_oe = w_phase & wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else if (w_next == S_LOW) begin
            sram_addr <= {w_word, 1'b0};
            if (wr_en) sram_dq_out <= write_data[15:0];
        end else if (w_next == S_HIGH) begin
            sram_addr <= {w_word, 1'b1};
            if (wr_en) sram_dq_out <= write_data[31:16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            read_data <= '0;
        end else if (w_is_rd & w_last) begin
            if (r_state == S_LOW)  read_data[15:0]  <= sram_dq_in;
            if (r_state == S_HIGH) read_data[31:16] <= sram_dq_in;
        end
    end

endmodule
